// File: rtl/trdb_stream_buf.sv
// Trace output buffer: FWFT FIFO for packet and register-dump words feeding a
// valid/ready stream, with a drain-then-confirm flush handshake to the register block.
module trdb_stream_buf #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_enable_i,
    input  logic                       packet_valid_i,
    input  logic [DATA_WIDTH-1:0]      packet_data_i,
    output logic                       packet_ready_o,
    input  logic                       dump_valid_i,
    input  logic [DATA_WIDTH-1:0]      dump_data_i,
    input  logic                       flush_stream_i,
    output logic                       flush_confirm_o,
    output logic                       stream_valid_o,
    output logic [DATA_WIDTH-1:0]      stream_data_o,
    input  logic                       stream_ready_i,
    output logic [$clog2(DEPTH):0]     fill_level_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CONFIRM, WAIT} state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           rptr_reg;
    logic [AW-1:0]           wptr_reg;
    logic [AW:0]             count_reg;
    logic                    overflow_reg;
    logic                    confirm_reg;

    logic                    full;
    logic                    empty;
    logic                    is_idle;
    logic                    push;
    logic                    pop;
    logic                    dump_drop;
    logic [DATA_WIDTH-1:0]   wdata;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign is_idle = (state_reg == IDLE);

    // Ready never looks at the sink side, so a full FIFO stalls the emitter even if a pop is due.
    assign packet_ready_o = ~rst_i & ~full & ~dump_valid_i & is_idle;

    // Dump strobes cannot be back-pressured: they win arbitration and are lost when they cannot land.
    assign push      = is_idle & (dump_valid_i ? ~full
                                               : (packet_valid_i & packet_ready_o & trace_enable_i));
    assign wdata     = dump_valid_i ? dump_data_i : packet_data_i;
    assign dump_drop = dump_valid_i & ((is_idle & full) | (state_reg == DRAIN) | (state_reg == WAIT));
    assign pop       = ~empty & stream_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            confirm_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            confirm_reg <= 1'b0;
            if (state_reg == CONFIRM) begin
                overflow_reg <= 1'b0;
            end else if (dump_drop) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (flush_stream_i) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The flush level is not re-sampled here: once started, a drain always confirms.
                    if (empty) begin
                        state_reg   <= CONFIRM;
                        confirm_reg <= 1'b1;
                    end
                end
                CONFIRM: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (!flush_stream_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign stream_valid_o  = ~empty;
    assign stream_data_o   = mem[rptr_reg];
    assign fill_level_o    = count_reg;
    assign flush_confirm_o = confirm_reg;
    assign overflow_o      = overflow_reg;

endmodule

// File: tb/tb_trdb_stream_buf.sv
// Bench for trdb_stream_buf: directed scenarios plus random traffic, all checked every
// cycle against a queue-based reference of the buffer and its flush handshake.
module tb_trdb_stream_buf;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          trace_enable_i;
    logic          packet_valid_i;
    logic [DW-1:0] packet_data_i;
    logic          packet_ready_o;
    logic          dump_valid_i;
    logic [DW-1:0] dump_data_i;
    logic          flush_stream_i;
    logic          flush_confirm_o;
    logic          stream_valid_o;
    logic [DW-1:0] stream_data_o;
    logic          stream_ready_i;
    logic [LW-1:0] fill_level_o;
    logic          overflow_o;

    trdb_stream_buf #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .trace_enable_i (trace_enable_i),
        .packet_valid_i (packet_valid_i),
        .packet_data_i  (packet_data_i),
        .packet_ready_o (packet_ready_o),
        .dump_valid_i   (dump_valid_i),
        .dump_data_i    (dump_data_i),
        .flush_stream_i (flush_stream_i),
        .flush_confirm_o(flush_confirm_o),
        .stream_valid_o (stream_valid_o),
        .stream_data_o  (stream_data_o),
        .stream_ready_i (stream_ready_i),
        .fill_level_o   (fill_level_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference: stored words in order, flush phase (0 idle, 1 draining, 2 confirming, 3 waiting).
    logic [DW-1:0] model_q[$];
    int            phase = 0;
    bit            model_ovf = 1'b0;
    bit            pkt_taken = 1'b0;
    bit            confirm_seen = 1'b0;
    int            popped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs are already driven; check outputs mid-cycle, then advance the reference.
    task automatic cycle();
        bit room;
        bit exp_ready;
        bit was_empty;
        @(negedge clk_i);
        if (rst_i) begin
            chk("rst_valid", 64'(stream_valid_o), 64'(0));
            chk("rst_fill", 64'(fill_level_o), 64'(0));
            chk("rst_confirm", 64'(flush_confirm_o), 64'(0));
            chk("rst_ready", 64'(packet_ready_o), 64'(0));
            chk("rst_ovf", 64'(overflow_o), 64'(0));
            model_q.delete();
            phase     = 0;
            model_ovf = 1'b0;
            pkt_taken = 1'b0;
        end else begin
            room      = model_q.size() < DEPTH;
            was_empty = model_q.size() == 0;
            exp_ready = room && !dump_valid_i && phase == 0;
            chk("valid", 64'(stream_valid_o), 64'(!was_empty));
            chk("fill", 64'(fill_level_o), 64'(model_q.size()));
            chk("ready", 64'(packet_ready_o), 64'(exp_ready));
            chk("confirm", 64'(flush_confirm_o), 64'(phase == 2));
            chk("overflow", 64'(overflow_o), 64'(model_ovf));
            if (!was_empty) chk("data", 64'(stream_data_o), 64'(model_q[0]));
            if (phase == 2) confirm_seen = 1'b1;
            pkt_taken = packet_valid_i && exp_ready;
            if (!was_empty && stream_ready_i) begin
                void'(model_q.pop_front());
                popped++;
            end
            if (phase == 0) begin
                if (dump_valid_i) begin
                    if (room) model_q.push_back(dump_data_i);
                    else      model_ovf = 1'b1;
                end else if (pkt_taken && trace_enable_i) begin
                    model_q.push_back(packet_data_i);
                end
            end else if (dump_valid_i && phase != 2) begin
                model_ovf = 1'b1;
            end
            case (phase)
                0: if (flush_stream_i) phase = 1;
                1: if (was_empty) phase = 2;
                2: begin phase = 3; model_ovf = 1'b0; end
                default: if (!flush_stream_i) phase = 0;
            endcase
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        packet_valid_i = 1'b0;
        dump_valid_i   = 1'b0;
        flush_stream_i = 1'b0;
    endtask

    task automatic drain_all();
        int guard = 0;
        quiet();
        stream_ready_i = 1'b1;
        while (model_q.size() != 0 && guard < 40) begin
            cycle();
            guard++;
        end
        chk("drain_done", 64'(fill_level_o), 64'(0));
    endtask

    initial begin
        int accepted;
        int guard;
        int flush_hold;
        rst_i          = 1'b1;
        trace_enable_i = 1'b1;
        packet_valid_i = 1'b1;
        packet_data_i  = 32'h55;
        dump_valid_i   = 1'b1;
        dump_data_i    = 32'h66;
        flush_stream_i = 1'b1;
        stream_ready_i = 1'b1;

        // Reset held with live stimulus
        cycle();
        cycle();
        rst_i = 1'b0;
        quiet();
        cycle();

        // Three packets streamed straight through
        for (int i = 0; i < 3; i++) begin
            packet_valid_i = 1'b1;
            packet_data_i  = 32'hA0 + 32'(i);
            cycle();
        end
        packet_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Fill to full with sink stalled, then a dump strobe that must overflow
        stream_ready_i = 1'b0;
        accepted = 0;
        guard    = 0;
        while (accepted < DEPTH && guard < 40) begin
            packet_valid_i = 1'b1;
            packet_data_i  = 32'h100 + 32'(accepted);
            cycle();
            if (pkt_taken) accepted++;
            guard++;
        end
        chk("full_fill", 64'(fill_level_o), 64'(DEPTH));
        chk("full_ready", 64'(packet_ready_o), 64'(0));
        packet_valid_i = 1'b0;
        dump_valid_i   = 1'b1;
        dump_data_i    = 32'hD;
        cycle();
        dump_valid_i = 1'b0;
        cycle();
        chk("overflow_set", 64'(overflow_o), 64'(1));
        drain_all();

        // Dump and packet in the same cycle: dump wins, packet held and taken next cycle
        stream_ready_i = 1'b0;
        dump_valid_i   = 1'b1;
        dump_data_i    = 32'hDD;
        packet_valid_i = 1'b1;
        packet_data_i  = 32'h11;
        cycle();
        chk("dump_prio_taken", 64'(pkt_taken), 64'(0));
        dump_valid_i = 1'b0;
        cycle();
        chk("held_pkt_taken", 64'(pkt_taken), 64'(1));
        packet_valid_i = 1'b0;
        chk("dump_head", 64'(stream_data_o), 64'(32'hDD));
        drain_all();

        // Five words queued, then flush with the sink ready
        stream_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            packet_valid_i = 1'b1;
            packet_data_i  = 32'hF0 + 32'(i);
            cycle();
        end
        packet_valid_i = 1'b0;
        flush_stream_i = 1'b1;
        stream_ready_i = 1'b1;
        confirm_seen   = 1'b0;
        guard          = 0;
        while (!confirm_seen && guard < 50) begin
            cycle();
            guard++;
        end
        chk("flush_confirm_seen", 64'(confirm_seen), 64'(1));
        for (int i = 0; i < 4; i++) cycle();
        flush_stream_i = 1'b0;
        cycle();
        cycle();
        chk("flush_ovf_cleared", 64'(overflow_o), 64'(0));

        // Flush with the FIFO already empty
        flush_stream_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        flush_stream_i = 1'b0;
        cycle();

        // Reset in the middle of a drain
        stream_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            packet_valid_i = 1'b1;
            packet_data_i  = $urandom;
            cycle();
        end
        packet_valid_i = 1'b0;
        flush_stream_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i          = 1'b0;
        flush_stream_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic with stalls, occasional dumps and flushes; emitter holds unaccepted words
        popped     = 0;
        flush_hold = 0;
        packet_valid_i = 1'b0;
        pkt_taken      = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!packet_valid_i || pkt_taken) begin
                packet_valid_i = ($urandom_range(0, 3) != 0);
                packet_data_i  = $urandom;
            end
            dump_valid_i   = ($urandom_range(0, 15) == 0);
            dump_data_i    = $urandom;
            stream_ready_i = ($urandom_range(0, 2) != 0);
            trace_enable_i = ($urandom_range(0, 9) != 0);
            if (flush_hold > 0) begin
                flush_hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                flush_hold = $urandom_range(1, 20);
            end
            flush_stream_i = (flush_hold > 0);
            cycle();
        end
        chk("wrap_words", 64'(popped >= 40), 64'(1));

        quiet();
        trace_enable_i = 1'b1;
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
